// File: rtl/uart_tx_drain_pkg.sv
// Shared constants for the UART transmit drain: FSM state encodings and the
// divisor value the baud generator holds before its first frame.
package uart_tx_drain_pkg;

  localparam int DEFAULT_DIV = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_START = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_STOP  = 3'd5;

endpackage

// File: rtl/uart_tx_drain_if.sv
// Read side of the UART byte FIFO as seen by the transmit drain.
// Handshake: re_o pops one byte at the clock edge where it is high; rdata_i
// holds that byte from the following cycle on; buffer_empty_i gates re_o.
interface uart_tx_drain_if #(
  parameter int DATA_WIDTH = 8
);
  import uart_tx_drain_pkg::*;

  logic                  re_o;
  logic                  buffer_empty_i;
  logic [DATA_WIDTH-1:0] rdata_i;

  modport master (
    output re_o,
    input  buffer_empty_i,
    input  rdata_i
  );

  modport slave (
    input  re_o,
    output buffer_empty_i,
    output rdata_i
  );

endinterface

// File: rtl/uart_tx_drain_baud_gen.sv
// Bit-period generator: latches the divisor on restart and ticks on the last
// clock of every bit period. tick_next_o predicts the tick one cycle early.
module uart_tx_drain_baud_gen
  import uart_tx_drain_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 restart_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o,
  output logic                 tick_next_o
);

  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == div_q - DIV_WIDTH'(1));

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (restart_i) begin
      // A zero divisor would never tick; treat it as one clock per bit.
      div_d = (div_i == '0) ? DIV_WIDTH'(1) : div_i;
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
    tick_next_o = (cnt_d == div_d - DIV_WIDTH'(1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q <= DIV_WIDTH'(DEFAULT_DIV);
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmit engine draining the byte FIFO: one pop per frame, 8N1/8N2
// framing LSB first, every output registered from next-state values.
module uart_tx_drain
  import uart_tx_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tx_en_i,
  input  logic [DIV_WIDTH-1:0] clks_per_bit_i,
  input  logic                 two_stop_i,
  uart_tx_drain_if.master      fifo,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2:0]           state_o
);

  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  two_stop_q, two_stop_d;
  logic                  tx_q, tx_d;
  logic                  re_q, re_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tick, tick_next, frame_ready;

  assign frame_ready = tx_en_i & ~fifo.buffer_empty_i;

  uart_tx_drain_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .restart_i   (state_q == ST_LOAD),
    .div_i       (clks_per_bit_i),
    .tick_o      (tick),
    .tick_next_o (tick_next)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    two_stop_d = two_stop_q;
    case (state_q)
      ST_IDLE:  if (frame_ready) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        shift_d    = fifo.rdata_i;
        two_stop_d = two_stop_i;
        state_d    = ST_START;
      end
      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d    = ST_STOP;
            stop_cnt_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_cnt_q == two_stop_q) state_d = frame_ready ? ST_FETCH : ST_IDLE;
          else                          stop_cnt_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are computed for the state about to be entered so the
    // registered copies line up with the state they describe.
    tx_d = 1'b1;
    if (state_d == ST_START)     tx_d = 1'b0;
    else if (state_d == ST_DATA) tx_d = shift_d[0];
    re_d   = (state_d == ST_FETCH);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_STOP) && (stop_cnt_d == two_stop_d) && tick_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      re_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      two_stop_q <= two_stop_d;
      tx_q       <= tx_d;
      re_q       <= re_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign fifo.re_o = re_q;
  assign tx_o      = tx_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed-plus-random bench for uart_tx_drain: a FIFO model feeds bytes and
// every transmitted frame is checked cycle by cycle against ideal 8N1/8N2 framing.
module tb_uart_tx_drain;
  import uart_tx_drain_pkg::*;

  localparam int DW  = 8;
  localparam int DVW = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           tx_en;
  logic [DVW-1:0] clks_per_bit;
  logic           two_stop;
  logic           tx_o, busy_o, done_o;
  logic [2:0]     state_o;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int re_cnt = 0;
  int busy_low_cnt = 0;

  always #5 clk = ~clk;

  uart_tx_drain_if #(.DATA_WIDTH(DW)) fifo ();

  uart_tx_drain #(.DATA_WIDTH(DW), .DIV_WIDTH(DVW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .tx_en_i        (tx_en),
    .clks_per_bit_i (clks_per_bit),
    .two_stop_i     (two_stop),
    .fifo           (fifo.master),
    .tx_o           (tx_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .state_o        (state_o)
  );

  // FIFO model: pops on re_o, data valid from the following cycle.
  always @(negedge clk) begin
    #1;
    if (fifo.re_o === 1'b1) begin
      re_cnt++;
      if (fifo_q.size() > 0) fifo.rdata_i = fifo_q.pop_front();
    end
    fifo.buffer_empty_i = (fifo_q.size() == 0);
    if (busy_o !== 1'b1) busy_low_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  function automatic logic exp_bit(input logic [DW-1:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= DW) return b[k-1];
    return 1'b1;
  endfunction

  // Count negedges until the start bit appears on the line.
  task automatic wait_start(input string tag, input int exp_wait);
    int cnt;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (tx_o !== 1'b0 && cnt < 300);
    check({tag, " start latency"}, cnt, exp_wait);
  endtask

  // Entered at the negedge of the first start-bit cycle.
  task automatic check_frame(input string tag, input int n, input logic ts,
                             input int act_at, input int act_kind);
    logic [DW-1:0] b;
    int nbits, done_n, done_at, idx;
    logic obs, s;
    if (exp_q.size() == 0) begin
      check({tag, " exp_q empty"}, 32'd0, 32'd1);
      return;
    end
    b = exp_q.pop_front();
    nbits = DW + 2 + int'(ts);
    done_n = 0;
    done_at = -1;
    for (int k = 0; k < nbits; k++) begin
      obs = 1'bx;
      for (int c = 0; c < n; c++) begin
        idx = k * n + c;
        if (idx > 0) @(negedge clk);
        if (idx == act_at) begin
          if (act_kind == 1) clks_per_bit = 16'd8;
          else if (act_kind == 2) tx_en = 1'b0;
          else if (act_kind == 3) begin
            rst = 1'b1;
            #1;
            check({tag, " async rst tx"}, tx_o, 1'b1);
            check({tag, " async rst busy"}, busy_o, 1'b0);
            check({tag, " async rst re"}, fifo.re_o, 1'b0);
            check({tag, " async rst state"}, state_o, ST_IDLE);
            return;
          end
        end
        s = tx_o;
        if (c == 0) obs = s;
        else if (s !== obs) obs = 1'bx;
        if (done_o === 1'b1) begin
          done_n++;
          done_at = idx;
        end
      end
      check($sformatf("%s bit%0d", tag, k), obs, exp_bit(b, k));
    end
    check({tag, " done count"}, done_n, 1);
    check({tag, " done cycle"}, done_at, nbits * n - 1);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, " idle state"}, state_o, ST_IDLE);
    check({tag, " idle busy"}, busy_o, 1'b0);
    check({tag, " idle tx"}, tx_o, 1'b1);
  endtask

  initial begin
    int re0, bl0;
    int n_a[5];
    logic ts_a[5];

    // 1: reset held with a non-empty FIFO and enable set
    rst = 1'b1;
    tx_en = 1'b1;
    clks_per_bit = 16'd4;
    two_stop = 1'b0;
    push(8'h3C);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t1 rst tx c%0d", i), tx_o, 1'b1);
      check($sformatf("t1 rst re c%0d", i), fifo.re_o, 1'b0);
      check($sformatf("t1 rst busy c%0d", i), busy_o, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("t1 re after release", fifo.re_o, 1'b1);
    check("t1 busy after release", busy_o, 1'b1);
    wait_start("t1", 2);
    check_frame("t1", 4, 1'b0, -1, 0);
    check_idle("t1");

    // 2: single byte 0xA5, N=4, one stop
    push(8'hA5);
    wait_start("t2", 3);
    check_frame("t2", 4, 1'b0, -1, 0);
    check_idle("t2");

    // 3: three queued bytes, N=2, two stop bits, back to back
    clks_per_bit = 16'd2;
    two_stop = 1'b1;
    re0 = re_cnt;
    for (int i = 0; i < 3; i++) push(DW'($urandom_range(0, 255)));
    wait_start("t3 f0", 3);
    bl0 = busy_low_cnt;
    check_frame("t3 f0", 2, 1'b1, -1, 0);
    wait_start("t3 f1", 3);
    check_frame("t3 f1", 2, 1'b1, -1, 0);
    wait_start("t3 f2", 3);
    check_frame("t3 f2", 2, 1'b1, -1, 0);
    check("t3 busy gaps", busy_low_cnt - bl0, 0);
    check_idle("t3");
    check("t3 pops", re_cnt - re0, 3);

    // 4: divisor 0 and 1 give one bit per clock; mid-frame divisor change
    two_stop = 1'b0;
    clks_per_bit = 16'd0;
    push(8'hFF);
    wait_start("t4 div0", 3);
    check_frame("t4 div0", 1, 1'b0, -1, 0);
    check_idle("t4 div0");
    clks_per_bit = 16'd1;
    push(DW'($urandom_range(0, 255)));
    push(DW'($urandom_range(0, 255)));
    wait_start("t4 div1", 3);
    check_frame("t4 div1", 1, 1'b0, 3, 1);
    wait_start("t4 div8", 3);
    check_frame("t4 div8", 8, 1'b0, -1, 0);
    check_idle("t4 div8");

    // 5: enable dropped in data bit 3 with more bytes waiting
    clks_per_bit = 16'd3;
    push(DW'($urandom_range(0, 255)));
    push(DW'($urandom_range(0, 255)));
    wait_start("t5", 3);
    re0 = re_cnt;
    check_frame("t5", 3, 1'b0, 4 * 3 + 1, 2);
    repeat (20) @(negedge clk);
    check("t5 no pop", re_cnt - re0, 0);
    check("t5 state", state_o, ST_IDLE);
    check("t5 fifo left", fifo_q.size(), 1);
    tx_en = 1'b1;
    wait_start("t5 resume", 3);
    check_frame("t5 resume", 3, 1'b0, -1, 0);
    check_idle("t5 resume");

    // 6: asynchronous reset during data bit 5
    clks_per_bit = 16'd2;
    push(DW'($urandom_range(0, 255)));
    wait_start("t6", 3);
    check_frame("t6", 2, 1'b0, 6 * 2 + 1, 3);
    repeat (2) @(negedge clk);
    check("t6 held busy", busy_o, 1'b0);
    push(DW'($urandom_range(0, 255)));
    rst = 1'b0;
    wait_start("t6 after", 3);
    check_frame("t6 after", 2, 1'b0, -1, 0);
    check_idle("t6 after");

    // 7: random back-to-back frames, config changed while each frame runs
    for (int j = 0; j < 5; j++) begin
      n_a[j] = int'($urandom_range(1, 5));
      ts_a[j] = 1'($urandom_range(0, 1));
    end
    clks_per_bit = DVW'(n_a[0]);
    two_stop = ts_a[0];
    for (int j = 0; j < 4; j++) push(DW'($urandom));
    for (int j = 0; j < 4; j++) begin
      wait_start($sformatf("t7 f%0d", j), 3);
      clks_per_bit = DVW'(n_a[j+1]);
      two_stop = ts_a[j+1];
      check_frame($sformatf("t7 f%0d", j), n_a[j], ts_a[j], -1, 0);
    end
    check_idle("t7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
